// File: rtl/rrip_req_arbiter_if.sv
// Bundle of the requester-side and engine-side signals of rrip_req_arbiter.
//   slave  : the arbiter's view (takes requests and the engine's victim result,
//            drives grants, responses and the engine command).
//   master : the environment's view (requesters plus the replacement engine).
// Signals:
//   req_valid/req_hit/req_set/req_way : packed per-requester request fields
//   req_ready/resp_valid              : one-hot grant and completion pulses
//   resp_way/resp_timeout             : completion payload, held between pulses
//   eng_*                             : DRRIP engine command and victim result
interface rrip_req_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int SET_INDEX_WIDTH = 7,
  parameter int WAY_BITS        = 4
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_hit;
  logic [NUM_REQ*SET_INDEX_WIDTH-1:0] req_set;
  logic [NUM_REQ*WAY_BITS-1:0]        req_way;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [WAY_BITS-1:0]                resp_way;
  logic                               resp_timeout;
  logic                               eng_valid;
  logic                               eng_hit;
  logic                               eng_miss;
  logic [SET_INDEX_WIDTH-1:0]         eng_set_index;
  logic [WAY_BITS-1:0]                eng_access_way;
  logic                               eng_victim_ready;
  logic [WAY_BITS-1:0]                eng_victim_way;

  modport slave (
    input  req_valid, req_hit, req_set, req_way,
    input  eng_victim_ready, eng_victim_way,
    output req_ready, resp_valid, resp_way, resp_timeout,
    output eng_valid, eng_hit, eng_miss, eng_set_index, eng_access_way
  );

  modport master (
    output req_valid, req_hit, req_set, req_way,
    output eng_victim_ready, eng_victim_way,
    input  req_ready, resp_valid, resp_way, resp_timeout,
    input  eng_valid, eng_hit, eng_miss, eng_set_index, eng_access_way
  );
endinterface

// File: rtl/rrip_req_arbiter.sv
// Round-robin front-end scheduler for the DRRIP replacement engine.
// Grants one of NUM_REQ requesters at a time, drives the engine with a single
// hit pulse or a held miss request, and returns the victim way (or a timeout
// abort) to the winner as a one-cycle one-hot resp_valid pulse.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : rrip_req_arbiter_if.slave (requests, responses, engine command)
//   busy     : high whenever a transaction is in flight (state != IDLE)
module rrip_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SET_INDEX_WIDTH = 7,
  parameter int WAY_BITS        = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  rrip_req_arbiter_if.slave bus,
  output logic              busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE_HIT = 2'd1;
  localparam logic [1:0] S_WAIT_MISS = 2'd2;
  localparam logic [1:0] S_RESP      = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]                 state;
  logic [PTR_W-1:0]           ptr;
  logic [PTR_W-1:0]           cap_idx;
  logic [SET_INDEX_WIDTH-1:0] cap_set;
  logic [WAY_BITS-1:0]        cap_way;
  logic [CNT_W-1:0]           tmo_cnt;
  logic [WAY_BITS-1:0]        resp_way_r;
  logic                       resp_timeout_r;

  logic                       grant_found;
  logic [PTR_W-1:0]           grant_idx;
  logic [PTR_W-1:0]           scan_idx;

  function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Winner: first valid requester scanning upward from ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Stage boundary: transaction state and captured request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      cap_idx        <= '0;
      cap_set        <= '0;
      cap_way        <= '0;
      tmo_cnt        <= '0;
      resp_way_r     <= '0;
      resp_timeout_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            cap_idx <= grant_idx;
            cap_set <= bus.req_set[int'(grant_idx)*SET_INDEX_WIDTH +: SET_INDEX_WIDTH];
            cap_way <= bus.req_way[int'(grant_idx)*WAY_BITS +: WAY_BITS];
            ptr     <= ptr_wrap_inc(grant_idx);
            tmo_cnt <= '0;
            state   <= bus.req_hit[grant_idx] ? S_ISSUE_HIT : S_WAIT_MISS;
          end
        end
        S_ISSUE_HIT: begin
          resp_way_r     <= cap_way;
          resp_timeout_r <= 1'b0;
          state          <= S_RESP;
        end
        S_WAIT_MISS: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          // A victim arriving on the last allowed cycle still counts as success.
          if (bus.eng_victim_ready) begin
            resp_way_r     <= bus.eng_victim_way;
            resp_timeout_r <= 1'b0;
            state          <= S_RESP;
          end else if (tmo_cnt == CNT_LAST) begin
            resp_way_r     <= '0;
            resp_timeout_r <= 1'b1;
            state          <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage boundary: outputs decoded from the current state.
  // RESP plus the following IDLE cycle give the engine a two-cycle
  // eng_valid gap so its once-per-miss PSEL flag can clear.
  always_comb begin
    bus.req_ready      = '0;
    bus.resp_valid     = '0;
    bus.eng_valid      = 1'b0;
    bus.eng_hit        = 1'b0;
    bus.eng_miss       = 1'b0;
    bus.eng_set_index  = '0;
    bus.eng_access_way = '0;
    case (state)
      S_IDLE: begin
        if (grant_found && !rst) bus.req_ready[grant_idx] = 1'b1;
      end
      S_ISSUE_HIT: begin
        bus.eng_valid      = 1'b1;
        bus.eng_hit        = 1'b1;
        bus.eng_set_index  = cap_set;
        bus.eng_access_way = cap_way;
      end
      S_WAIT_MISS: begin
        bus.eng_valid     = !bus.eng_victim_ready;
        bus.eng_miss      = !bus.eng_victim_ready;
        bus.eng_set_index = cap_set;
      end
      S_RESP: begin
        bus.resp_valid[cap_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.resp_way     = resp_way_r;
  assign bus.resp_timeout = resp_timeout_r;
  assign busy             = (state != S_IDLE);
endmodule

// File: doc/rrip_req_arbiter.md
Name: rrip_req_arbiter

Overview:
- Front-end scheduler for the DRRIP replacement engine.
- Accepts hit/miss replacement transactions from NUM_REQ independent requesters (L1 refill ports, prefetcher) and grants one at a time, round-robin.
- Drives the engine's valid/hit/miss/set/way inputs with the exact hold and gap timing the engine needs, then returns the victim way, or a timeout, to the winning requester.

Parameters:
- NUM_REQ, 4, number of requesters.
- SET_INDEX_WIDTH, 7, set index width; must match the engine.
- WAY_BITS, 4, way index width.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT_MISS before a forced abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_hit  in  NUM_REQ  1 = hit promotion, 0 = miss/victim request.
- req_set  in  NUM_REQ*SET_INDEX_WIDTH  packed set indices; requester i occupies slice i.
- req_way  in  NUM_REQ*WAY_BITS  packed hit ways; ignored for misses.
- req_ready  out  NUM_REQ  one-hot grant pulse.
- resp_valid  out  NUM_REQ  one-hot completion pulse.
- resp_way  out  WAY_BITS  victim way (miss) or echoed way (hit).
- resp_timeout  out  1  qualifies resp_valid; miss aborted.
- eng_valid  out  1  to engine valid.
- eng_hit  out  1  to engine hit.
- eng_miss  out  1  to engine miss.
- eng_set_index  out  SET_INDEX_WIDTH  to engine set_index.
- eng_access_way  out  WAY_BITS  to engine access_way.
- eng_victim_ready  in  1  from engine victim_ready.
- eng_victim_way  in  WAY_BITS  from engine victim_way.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clock edge), also when asserted mid-transaction:
  - State goes to IDLE and the round-robin pointer goes to 0.
  - Timeout counter and captured registers go to 0.
  - All outputs are 0.
  - The in-flight transaction is dropped with no resp_valid.
- States: IDLE, ISSUE_HIT, WAIT_MISS, RESP.
- IDLE:
  - If any req_valid, choose winner w as the first set bit scanning from ptr upward with wrap.
  - req_ready[w]=1 combinationally in this cycle; the requester must hold its inputs stable until then.
  - Capture w, req_hit[w], req_set slice w and req_way slice w.
  - Set ptr=(w+1) mod NUM_REQ.
  - Next state is ISSUE_HIT if hit, else WAIT_MISS.
  - eng_* outputs are all 0 in IDLE.
- ISSUE_HIT:
  - Exactly one cycle of eng_valid=1, eng_hit=1, eng_miss=0, with the captured set and way.
  - Next state is RESP with resp_way = captured way.
- WAIT_MISS:
  - eng_valid=eng_miss = !eng_victim_ready; eng_hit=0; eng_set_index = captured set, held stable.
  - eng_access_way=0.
  - Timeout counter increments each cycle in this state.
  - When eng_victim_ready=1: capture eng_victim_way into resp_way, set timeout flag=0, go to RESP.
  - Otherwise, when counter == TIMEOUT_CYCLES-1: set timeout flag=1, resp_way=0, go to RESP.
  - If victim_ready and the timeout limit occur in the same cycle, victim_ready wins with timeout=0.
  - The counter clears on entry to WAIT_MISS.
- RESP:
  - One cycle of resp_valid[w]=1, with resp_timeout = flag and resp_way valid.
  - eng_valid=0. Next state is IDLE.
- Gap guarantee: RESP and the following IDLE cycle keep eng_valid low for at least 2 cycles between transactions. This lets the engine's PSEL once-per-miss flag clear.
- Latency, with the grant in cycle G:
  - Hit: engine sees the hit at G+1; resp_valid at G+2.
  - Miss: eng_valid rises at G+1. With victim_ready first seen high at cycle V, resp_valid is at V+1.
- Unused resp_valid bits are 0.
- resp_way and resp_timeout hold their last values outside RESP.
- A requester dropping req_valid before its grant is legal and loses arbitration with no side effects.
- Back-to-back requests from one requester are granted at most once every NUM_REQ grants while others are pending.

Test Plan:
- Reset, then req 0 miss on set 5 with the engine instantiated (all RRPV=3): grant at G; eng_valid/eng_miss high G+1..G+3, low at G+4 when victim_ready rises. resp_valid[0] at G+5, resp_way=0, resp_timeout=0.
- Req 2 hit on set 9 way 3 at G: eng_hit is a 1-cycle pulse at G+1 with set 9, way 3. resp_valid[2] at G+2 with resp_way=3.
- All 4 requesters assert misses simultaneously, each held until its grant: grants in order 0,1,2,3. req_ready is one-hot. eng_valid is low ≥2 cycles between transactions. PSEL changes by exactly 1 per leader-set miss.
- Engine stubbed with victim_ready tied 0, TIMEOUT_CYCLES=8: eng_miss is high for 8 cycles. resp_valid with resp_timeout=1 and resp_way=0, then IDLE.
- Stub raises victim_ready in the exact cycle the counter hits 7: resp_timeout=0 and resp_way = stub way.
- rst asserted during WAIT_MISS: next cycle all outputs 0 and busy=0. No resp_valid. The next grant goes to requester 0.
